// File: rtl/sht40_meas_sequencer.sv
// Periodic SHT40 measurement sequencer: issues the measure-command write,
// waits for conversion, issues the read, validates both words and retries
// failed cycles before publishing results or reporting a failure.
module sht40_meas_sequencer #(
  parameter logic [6:0]  DEV_ADDR         = 7'h44,
  parameter logic [7:0]  MEAS_CMD         = 8'hFD,
  parameter int unsigned MEAS_WAIT_CYCLES = 1000,
  parameter int unsigned PERIOD_CYCLES    = 5000,
  parameter int unsigned TIMEOUT_CYCLES   = 4095,
  parameter int unsigned MAX_RETRIES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Enable,
  input  logic [2:0]  Master_State_Out,
  input  logic        CRC_Error,
  input  logic        Temp_Ready_Out,
  input  logic        RH_Ready_Out,
  input  logic [15:0] Temperature_Output,
  input  logic [15:0] Humidity_Output,
  output logic        Processor_Ready,
  output logic        i2c_writes,
  output logic [6:0]  Peripheral_Address,
  output logic [7:0]  Command_Data_Frames,
  output logic [15:0] Temp_Result,
  output logic [15:0] RH_Result,
  output logic        Result_Valid,
  output logic        Fail_Pulse,
  output logic [7:0]  Error_Count,
  output logic [2:0]  Seq_State
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned RTY_W  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ERR_W  = 8;

  localparam logic [CNT_W-1:0] MEAS_LOAD   = CNT_W'(MEAS_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);
  localparam logic [ERR_W-1:0] ERR_SAT     = '1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WR_REQ      = 3'd1,
    S_WR_WAIT     = 3'd2,
    S_MEAS_WAIT   = 3'd3,
    S_RD_REQ      = 3'd4,
    S_RD_WAIT     = 3'd5,
    S_CHECK       = 3'd6,
    S_PERIOD_WAIT = 3'd7
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [CNT_W-1:0]    r_wait_cnt,   w_wait_nxt;
  logic [CNT_W-1:0]    r_tmo_cnt,    w_tmo_nxt;
  logic [RTY_W-1:0]    r_retry,      w_retry_nxt;
  logic [ERR_W-1:0]    r_err_cnt,    w_err_nxt;
  logic                r_temp_seen,  w_temp_seen_nxt;
  logic                r_rh_seen,    w_rh_seen_nxt;
  logic                r_crc_bad,    w_crc_bad_nxt;
  logic                r_force_fail, w_force_fail_nxt;
  logic [DATA_W-1:0]   r_temp_sh,    w_temp_sh_nxt;
  logic [DATA_W-1:0]   r_rh_sh,      w_rh_sh_nxt;
  logic [DATA_W-1:0]   r_temp_res,   w_temp_res_nxt;
  logic [DATA_W-1:0]   r_rh_res,     w_rh_res_nxt;
  logic                r_proc_ready, w_proc_ready_nxt;
  logic                r_wr_mode,    w_wr_mode_nxt;
  logic                r_res_valid,  w_res_valid_nxt;
  logic                r_fail,       w_fail_nxt;

  logic w_master_idle;
  logic w_tmo_hit;
  logic w_ok;

  assign w_master_idle = (Master_State_Out == 3'b000);
  assign w_tmo_hit     = (r_tmo_cnt == TMO_LAST);
  assign w_ok          = r_temp_seen & r_rh_seen & ~r_crc_bad & ~r_force_fail;

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_retry      <= '0;
      r_err_cnt    <= '0;
      r_temp_seen  <= 1'b0;
      r_rh_seen    <= 1'b0;
      r_crc_bad    <= 1'b0;
      r_force_fail <= 1'b0;
      r_temp_sh    <= '0;
      r_rh_sh      <= '0;
      r_temp_res   <= '0;
      r_rh_res     <= '0;
      r_proc_ready <= 1'b0;
      r_wr_mode    <= 1'b1;
      r_res_valid  <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_retry      <= w_retry_nxt;
      r_err_cnt    <= w_err_nxt;
      r_temp_seen  <= w_temp_seen_nxt;
      r_rh_seen    <= w_rh_seen_nxt;
      r_crc_bad    <= w_crc_bad_nxt;
      r_force_fail <= w_force_fail_nxt;
      r_temp_sh    <= w_temp_sh_nxt;
      r_rh_sh      <= w_rh_sh_nxt;
      r_temp_res   <= w_temp_res_nxt;
      r_rh_res     <= w_rh_res_nxt;
      r_proc_ready <= w_proc_ready_nxt;
      r_wr_mode    <= w_wr_mode_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_fail       <= w_fail_nxt;
    end
  end

  // Next-state, counters, flags and output next-values
  always_comb begin
    w_state_nxt      = r_state;
    w_wait_nxt       = r_wait_cnt;
    w_tmo_nxt        = '0;
    w_retry_nxt      = r_retry;
    w_err_nxt        = r_err_cnt;
    w_temp_seen_nxt  = r_temp_seen;
    w_rh_seen_nxt    = r_rh_seen;
    w_crc_bad_nxt    = r_crc_bad;
    w_force_fail_nxt = r_force_fail;
    w_temp_sh_nxt    = r_temp_sh;
    w_rh_sh_nxt      = r_rh_sh;
    w_temp_res_nxt   = r_temp_res;
    w_rh_res_nxt     = r_rh_res;
    w_res_valid_nxt  = 1'b0;
    w_fail_nxt       = 1'b0;
    w_wr_mode_nxt    = r_wr_mode;

    unique case (r_state)
      S_IDLE: begin
        if (Enable) w_state_nxt = S_WR_REQ;
      end

      S_WR_REQ: begin
        if (!w_master_idle) begin
          w_state_nxt = S_WR_WAIT;
        end else if (w_tmo_hit) begin
          w_state_nxt      = S_CHECK;
          w_force_fail_nxt = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
        end
      end

      S_WR_WAIT: begin
        if (w_master_idle) begin
          w_state_nxt = S_MEAS_WAIT;
          w_wait_nxt  = MEAS_LOAD;
        end else if (w_tmo_hit) begin
          w_state_nxt      = S_CHECK;
          w_force_fail_nxt = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
        end
      end

      S_MEAS_WAIT: begin
        if (r_wait_cnt == '0) w_state_nxt = S_RD_REQ;
        else                  w_wait_nxt  = r_wait_cnt - CNT_W'(1);
      end

      S_RD_REQ: begin
        if (!w_master_idle) begin
          w_state_nxt     = S_RD_WAIT;
          w_temp_seen_nxt = 1'b0;
          w_rh_seen_nxt   = 1'b0;
          w_crc_bad_nxt   = 1'b0;
        end else if (w_tmo_hit) begin
          w_state_nxt      = S_CHECK;
          w_force_fail_nxt = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
        end
      end

      S_RD_WAIT: begin
        if (Temp_Ready_Out) begin
          w_temp_seen_nxt = 1'b1;
          w_temp_sh_nxt   = Temperature_Output;
        end
        if (RH_Ready_Out) begin
          w_rh_seen_nxt = 1'b1;
          w_rh_sh_nxt   = Humidity_Output;
        end
        if (CRC_Error) w_crc_bad_nxt = 1'b1;
        if (w_master_idle) begin
          w_state_nxt = S_CHECK;
        end else if (w_tmo_hit) begin
          w_state_nxt      = S_CHECK;
          w_force_fail_nxt = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        w_force_fail_nxt = 1'b0;
        if (w_ok) begin
          w_temp_res_nxt  = r_temp_sh;
          w_rh_res_nxt    = r_rh_sh;
          w_res_valid_nxt = 1'b1;
          w_retry_nxt     = '0;
          w_state_nxt     = S_PERIOD_WAIT;
          w_wait_nxt      = PERIOD_LOAD;
        end else begin
          if (r_err_cnt != ERR_SAT) w_err_nxt = r_err_cnt + ERR_W'(1);
          if (r_retry < RTY_MAX) begin
            w_retry_nxt = r_retry + RTY_W'(1);
            w_state_nxt = S_WR_REQ;
          end else begin
            w_retry_nxt = '0;
            w_fail_nxt  = 1'b1;
            w_state_nxt = S_PERIOD_WAIT;
            w_wait_nxt  = PERIOD_LOAD;
          end
        end
      end

      S_PERIOD_WAIT: begin
        if (r_wait_cnt == '0) w_state_nxt = Enable ? S_WR_REQ : S_IDLE;
        else                  w_wait_nxt  = r_wait_cnt - CNT_W'(1);
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Request line follows the next state so acceptance drops it in the same update
    w_proc_ready_nxt = (w_state_nxt == S_WR_REQ) || (w_state_nxt == S_RD_REQ);
    if (w_state_nxt == S_WR_REQ)      w_wr_mode_nxt = 1'b1;
    else if (w_state_nxt == S_RD_REQ) w_wr_mode_nxt = 1'b0;
  end

  assign Processor_Ready     = r_proc_ready;
  assign i2c_writes          = r_wr_mode;
  assign Peripheral_Address  = DEV_ADDR;
  assign Command_Data_Frames = MEAS_CMD;
  assign Temp_Result         = r_temp_res;
  assign RH_Result           = r_rh_res;
  assign Result_Valid        = r_res_valid;
  assign Fail_Pulse          = r_fail;
  assign Error_Count         = r_err_cnt;
  assign Seq_State           = r_state;

endmodule
